// File: rtl/mci_port_arbiter.sv
// mci_port_arbiter
//   Shares one main-memory controller port between two requesters:
//   requester 0 is the instruction fetch unit, requester 1 is the data
//   memory unit. Arbitration is round-robin, and only one transaction is
//   outstanding at a time. The request is issued from registers, and the
//   response is routed from registers back to the requester that owns the
//   grant.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  response timeout in cycles (1..65535); used only when
//            MCI_ARB_TIMEOUT_EN is defined
//
// Optional feature
//   `define MCI_ARB_TIMEOUT_EN builds a 16-bit response timer. When the
//   timer expires, the transaction is aborted: the owner's rsp_valid and
//   o_err pulse together, and rdata is 0. Without the macro, o_err is tied
//   to 0 and the arbiter waits indefinitely.
//
// Ports
//   i_clk, i_reset_n               clock (rising edge) and async active-low reset
//   i_pN_req_valid/addr/we/wdata   requester N request, held until its response
//   o_pN_rsp_valid/rdata           requester N one-cycle response and read data
//   o_m_req_valid, i_m_req_ready   memory request handshake
//   o_m_addr/we/wdata              issued request fields
//   i_m_rsp_valid, i_m_rdata       memory response pulse and data
//   o_err                          timeout abort pulse
//   o_grant                        one-hot current owner, 00 when idle
module mci_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_p0_req_valid,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic              i_p0_we,
  input  logic [DATA_W-1:0] i_p0_wdata,
  output logic              o_p0_rsp_valid,
  output logic [DATA_W-1:0] o_p0_rdata,
  input  logic              i_p1_req_valid,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic              i_p1_we,
  input  logic [DATA_W-1:0] i_p1_wdata,
  output logic              o_p1_rsp_valid,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic              o_m_req_valid,
  input  logic              i_m_req_ready,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic              o_m_we,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic              i_m_rsp_valid,
  input  logic [DATA_W-1:0] i_m_rdata,
  output logic              o_err,
  output logic [1:0]        o_grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic              m_req_valid_q, m_req_valid_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_we_q, m_we_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              p0_rsp_valid_q, p0_rsp_valid_d;
  logic              p1_rsp_valid_q, p1_rsp_valid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic pick_valid;
  logic pick;
  logic owner;
  logic complete;
  logic expire;

  assign owner = grant_q[1];

  // A response in the same cycle as the handshake is a zero-latency completion.
  assign complete = ((state_q == ISSUE) && i_m_req_ready && i_m_rsp_valid) ||
                    ((state_q == WAIT_RSP) && i_m_rsp_valid);

`ifdef MCI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  // Expiry is seen one cycle early so that the abort pulse lands TIMEOUT
  // cycles after ISSUE entry. A response in that same cycle takes priority.
  assign expire = (state_q != IDLE) && (cnt_q == 16'(TIMEOUT - 1)) && !complete;
  assign o_err  = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expire = 1'b0;
  assign o_err  = 1'b0;
`endif

  // While a response pulse is out, the served requester has not yet had a
  // chance to drop its request, so no new grant is made in that cycle.
  always_comb begin
    pick_valid = 1'b0;
    pick       = 1'b0;
    if (!(p0_rsp_valid_q || p1_rsp_valid_q)) begin
      if (i_p0_req_valid && i_p1_req_valid) begin
        pick_valid = 1'b1;
        pick       = ~last_q;
      end else if (i_p0_req_valid) begin
        pick_valid = 1'b1;
      end else if (i_p1_req_valid) begin
        pick_valid = 1'b1;
        pick       = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pick_valid) state_d = ISSUE;
      ISSUE:    if (complete || expire) state_d = IDLE;
                else if (i_m_req_ready) state_d = WAIT_RSP;
      WAIT_RSP: if (complete || expire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d        = grant_q;
    last_d         = last_q;
    m_req_valid_d  = m_req_valid_q;
    m_addr_d       = m_addr_q;
    m_we_d         = m_we_q;
    m_wdata_d      = m_wdata_q;
    p0_rsp_valid_d = 1'b0;
    p1_rsp_valid_d = 1'b0;
    p0_rdata_d     = p0_rdata_q;
    p1_rdata_d     = p1_rdata_q;
`ifdef MCI_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_d          = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (pick_valid) begin
        grant_d       = pick ? 2'b10 : 2'b01;
        m_req_valid_d = 1'b1;
        m_addr_d      = pick ? i_p1_addr  : i_p0_addr;
        m_we_d        = pick ? i_p1_we    : i_p0_we;
        m_wdata_d     = pick ? i_p1_wdata : i_p0_wdata;
`ifdef MCI_ARB_TIMEOUT_EN
        cnt_d         = '0;
`endif
      end
    end else begin
`ifdef MCI_ARB_TIMEOUT_EN
      cnt_d = cnt_q + 16'd1;
`endif
      if ((state_q == ISSUE) && i_m_req_ready) m_req_valid_d = 1'b0;
      if (complete || expire) begin
        m_req_valid_d = 1'b0;
        grant_d       = 2'b00;
        last_d        = owner;
        if (owner) begin
          p1_rsp_valid_d = 1'b1;
          p1_rdata_d     = complete ? i_m_rdata : '0;
        end else begin
          p0_rsp_valid_d = 1'b1;
          p0_rdata_d     = complete ? i_m_rdata : '0;
        end
`ifdef MCI_ARB_TIMEOUT_EN
        err_d = expire;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      grant_q        <= 2'b00;
      last_q         <= 1'b1;
      m_req_valid_q  <= 1'b0;
      m_addr_q       <= '0;
      m_we_q         <= 1'b0;
      m_wdata_q      <= '0;
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
      p0_rdata_q     <= '0;
      p1_rdata_q     <= '0;
`ifdef MCI_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      grant_q        <= grant_d;
      last_q         <= last_d;
      m_req_valid_q  <= m_req_valid_d;
      m_addr_q       <= m_addr_d;
      m_we_q         <= m_we_d;
      m_wdata_q      <= m_wdata_d;
      p0_rsp_valid_q <= p0_rsp_valid_d;
      p1_rsp_valid_q <= p1_rsp_valid_d;
      p0_rdata_q     <= p0_rdata_d;
      p1_rdata_q     <= p1_rdata_d;
`ifdef MCI_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign o_grant        = grant_q;
  assign o_m_req_valid  = m_req_valid_q;
  assign o_m_addr       = m_addr_q;
  assign o_m_we         = m_we_q;
  assign o_m_wdata      = m_wdata_q;
  assign o_p0_rsp_valid = p0_rsp_valid_q;
  assign o_p1_rsp_valid = p1_rsp_valid_q;
  assign o_p0_rdata     = p0_rdata_q;
  assign o_p1_rdata     = p1_rdata_q;

endmodule

// File: tb/tb_mci_port_arbiter.sv
// Directed bench for mci_port_arbiter. Stimulus pushes expected responses
// into a scoreboard queue; a negedge monitor pops and compares whenever a
// response pulse appears.
module tb_mci_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_rsp, p1_rsp;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          m_req_valid, m_we;
  logic          m_req_ready = 1'b0, m_rsp_valid = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          err;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  mci_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_p0_req_valid(p0_req), .i_p0_addr(p0_addr), .i_p0_we(p0_we), .i_p0_wdata(p0_wdata),
    .o_p0_rsp_valid(p0_rsp), .o_p0_rdata(p0_rdata),
    .i_p1_req_valid(p1_req), .i_p1_addr(p1_addr), .i_p1_we(p1_we), .i_p1_wdata(p1_wdata),
    .o_p1_rsp_valid(p1_rsp), .o_p1_rdata(p1_rdata),
    .o_m_req_valid(m_req_valid), .i_m_req_ready(m_req_ready),
    .o_m_addr(m_addr), .o_m_we(m_we), .o_m_wdata(m_wdata),
    .i_m_rsp_valid(m_rsp_valid), .i_m_rdata(m_rdata),
    .o_err(err), .o_grant(grant)
  );

  typedef struct {
    logic [1:0]    port;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] port, input logic [DW-1:0] data, input logic e);
    exp_t x;
    x.port = port; x.data = data; x.err = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n && (p0_rsp || p1_rsp || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {61'd0, p1_rsp, p0_rsp, err}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_port", {62'd0, p1_rsp, p0_rsp}, {62'd0, e.port});
        chk("rsp_data", {32'd0, (e.port == 2'b10) ? p1_rdata : p0_rdata}, {32'd0, e.data});
        chk("rsp_err", {63'd0, err}, {63'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    m_req_ready = 0; m_rsp_valid = 0; m_rdata = '0;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_ctrl"}, {58'd0, m_req_valid, m_we, p0_rsp, p1_rsp, err, (grant != 2'b00)}, 64'd0);
    chk({nm, "_maddr"}, {32'd0, m_addr}, 64'd0);
    chk({nm, "_mwdata"}, {32'd0, m_wdata}, 64'd0);
    chk({nm, "_rdata"}, {p1_rdata, p0_rdata}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk_zero_outputs("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_mreq(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (m_req_valid) seen = 1;
    end
    if (!seen) chk("mreq_wait_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] prev [2];
    int            hs;
    #3;
    // Single read from p0.
    do_reset();
    p0_req = 1; p0_addr = 32'h100; m_req_ready = 1;
    tick();
    chk("t1_mreq_valid", {63'd0, m_req_valid}, 64'd1);
    chk("t1_grant", {62'd0, grant}, 64'd1);
    chk("t1_addr_we", {31'd0, m_we, m_addr}, {31'd0, 1'b0, 32'h100});
    tick();
    chk("t1_mreq_drop", {63'd0, m_req_valid}, 64'd0);
    tick();
    m_rsp_valid = 1; m_rdata = 32'hDEADBEEF;
    push(2'b01, 32'hDEADBEEF, 1'b0);
    tick();
    m_rsp_valid = 0; p0_req = 0;
    chk("t1_grant_idle", {62'd0, grant}, 64'd0);
    tick(); tick();

    // Simultaneous requests: alternating order, routed to owner only.
    do_reset();
    p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_addr = 32'h20; m_req_ready = 1;
    prev[0] = '0; prev[1] = '0;
    for (int k = 0; k < 4; k++) begin
      wait_mreq(10);
      chk("t2_order", {32'd0, m_addr}, (k % 2) ? 64'h20 : 64'h10);
      chk("t2_grant", {62'd0, grant}, (k % 2) ? 64'd2 : 64'd1);
      tick();
      m_rsp_valid = 1; m_rdata = 32'hA000_0000 + DW'(k);
      push((k % 2) ? 2'b10 : 2'b01, 32'hA000_0000 + DW'(k), 1'b0);
      tick();
      m_rsp_valid = 0;
      if (k == 3) begin p0_req = 0; p1_req = 0; end
      chk("t2_other_rdata_held", {32'd0, (k % 2) ? p0_rdata : p1_rdata},
          {32'd0, prev[(k % 2) ? 0 : 1]});
      prev[k % 2] = 32'hA000_0000 + DW'(k);
    end
    tick(); tick();
    chk("t2_quiet", {62'd0, m_req_valid, (grant != 2'b00)}, 64'd0);

    // Backpressure on a p1 write.
    do_reset();
    p1_req = 1; p1_we = 1; p1_addr = 32'h40; p1_wdata = 32'h55;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_valid_held", {63'd0, m_req_valid}, 64'd1);
      chk("t3_fields_stable", {m_we, m_addr[30:0], m_wdata}, {1'b1, 31'h40, 32'h55});
      if (i == 5) m_req_ready = 1;
      if (m_req_valid && m_req_ready) hs++;
    end
    tick();
    chk("t3_valid_drop", {63'd0, m_req_valid}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (m_req_valid && m_req_ready) hs++;
    end
    m_rsp_valid = 1; m_rdata = 32'h1234;
    push(2'b10, 32'h1234, 1'b0);
    tick();
    m_rsp_valid = 0; p1_req = 0;
    chk("t3_handshakes", 64'(hs), 64'd1);
    chk("t3_p0_rdata_held", {32'd0, p0_rdata}, 64'd0);
    tick(); tick();

    // Zero-latency memory, then p1 granted the cycle after the pulse.
    do_reset();
    p0_req = 1; p0_addr = 32'h200; p1_req = 1; p1_addr = 32'h300; m_req_ready = 1;
    tick();
    chk("t4_grant_p0", {62'd0, grant}, 64'd1);
    m_rsp_valid = 1; m_rdata = 32'hCAFE0001;
    push(2'b01, 32'hCAFE0001, 1'b0);
    tick();
    m_rsp_valid = 0; p0_req = 0;
    chk("t4_pulse_grant", {62'd0, grant}, 64'd0);
    tick();
    chk("t4_no_grant_yet", {62'd0, grant}, 64'd0);
    tick();
    chk("t4_p1_grant", {29'd0, m_req_valid, grant, m_addr}, {29'd0, 1'b1, 2'b10, 32'h300});
    tick();
    m_rsp_valid = 1; m_rdata = 32'hCAFE0002;
    push(2'b10, 32'hCAFE0002, 1'b0);
    tick();
    m_rsp_valid = 0; p1_req = 0;
    tick(); tick();

    // Reset in WAIT_RSP; a late memory response must be ignored.
    do_reset();
    p0_req = 1; p0_addr = 32'h500; p0_wdata = 32'h77; p0_we = 1; m_req_ready = 1;
    tick();
    chk("t5_issue", {31'd0, m_req_valid, m_addr}, {31'd0, 1'b1, 32'h500});
    tick();
    rst_n = 0; p0_req = 0; m_req_ready = 0;
    #1;
    chk_zero_outputs("t5_mid_reset");
    tick();
    rst_n = 1;
    tick();
    m_rsp_valid = 1; m_rdata = 32'hBAD0BAD0;
    tick();
    m_rsp_valid = 0;
    tick(); tick();
    chk_zero_outputs("t5_after_release");

`ifdef MCI_ARB_TIMEOUT_EN
    // Timeout: p0 never answered, p1 pending and granted afterwards.
    do_reset();
    p0_req = 1; p0_addr = 32'h600; p1_req = 1; p1_addr = 32'h700; m_req_ready = 1;
    tick();
    chk("t6_grant_p0", {62'd0, grant}, 64'd1);
    push(2'b01, 32'h0, 1'b1);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("t6_no_early_pulse", {62'd0, p0_rsp, err}, 64'd0);
    end
    tick();
    chk("t6_abort_pulse", {61'd0, p0_rsp, err, m_req_valid}, {61'd0, 3'b110});
    p0_req = 0;
    tick(); tick();
    chk("t6_p1_next", {29'd0, m_req_valid, grant, m_addr}, {29'd0, 1'b1, 2'b10, 32'h700});
    tick();
    m_rsp_valid = 1; m_rdata = 32'h0000_0700;
    push(2'b10, 32'h0000_0700, 1'b0);
    tick();
    m_rsp_valid = 0; p1_req = 0;
    tick(); tick();
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mci_port_arbiter.md
Name: mci_port_arbiter

Overview:
- Shares the single main-memory controller port between two CPU requesters.
- Requester 0 is the instruction fetch unit. Requester 1 is the data memory unit.
- Round-robin arbitration, one outstanding transaction at a time.
- Registered request issue and registered response routing back to the requester that owns the grant.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT, 255, cycles to wait for a memory response before aborting (used only with the optional feature). Legal range 1..65535.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_p0_req_valid  in  1  requester 0 request; held until its o_p0_rsp_valid
- i_p0_addr  in  ADDR_W  requester 0 address
- i_p0_we  in  1  requester 0 write enable
- i_p0_wdata  in  DATA_W  requester 0 write data
- o_p0_rsp_valid  out  1  requester 0 response, one-cycle pulse
- o_p0_rdata  out  DATA_W  requester 0 read data, valid with rsp_valid
- i_p1_req_valid, i_p1_addr, i_p1_we, i_p1_wdata  in  1/ADDR_W/1/DATA_W  requester 1 request, same rules as requester 0
- o_p1_rsp_valid, o_p1_rdata  out  1/DATA_W  requester 1 response
- o_m_req_valid  out  1  request to memory controller
- i_m_req_ready  in  1  memory controller accepts the request when valid&&ready
- o_m_addr, o_m_we, o_m_wdata  out  ADDR_W/1/DATA_W  issued request fields
- i_m_rsp_valid  in  1  memory controller response pulse
- i_m_rdata  in  DATA_W  response data
- o_err  out  1  one-cycle pulse when a transaction aborts on timeout
- o_grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; last-served pointer = 1, so requester 0 wins the first tie.
- FSM states are IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - If exactly one req_valid is high, grant it.
  - If both are high, grant the requester not served last.
  - On grant, latch addr/we/wdata into output registers, set o_grant, go to ISSUE.
  - o_m_req_valid rises the cycle after the requester's first valid cycle.
- ISSUE:
  - o_m_req_valid = 1 with fields stable until i_m_req_ready.
  - On the handshake cycle, drop o_m_req_valid next cycle and go to WAIT_RSP.
- WAIT_RSP:
  - On i_m_rsp_valid, register i_m_rdata to the granted requester's rdata.
  - Pulse that requester's rsp_valid the next cycle, update the last-served pointer, clear o_grant, return to IDLE.
  - A new grant can be made in the cycle after the response pulse. The served requester has then seen its response and may have dropped or renewed its request.
- i_m_rsp_valid arriving in the same cycle as the handshake (zero-latency memory) is legal: it is treated as WAIT_RSP completion, and ISSUE goes directly to IDLE with the response pulse.
- i_m_rsp_valid in IDLE is ignored. No response pulse is issued.
- A requester dropping req_valid while granted is a protocol violation. The arbiter completes the transaction and still pulses the response.
- Write transactions also wait for i_m_rsp_valid (write acknowledge). rdata is forwarded unchanged.
- The non-granted requester's rsp_valid stays 0 and its rdata holds its last value.
- Minimum transaction time is 3 cycles: request, issue, response pulse.
- Back-to-back alternating grants are required when both requesters remain valid.
- Asserting reset mid-transaction aborts immediately. Any later memory response is ignored as an IDLE response.

Optional Feature:
- Macro: MCI_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_RSP.
  - When it reaches TIMEOUT without completion, the FSM:
    - drops o_m_req_valid;
    - pulses the owner's rsp_valid with rdata = 0;
    - pulses o_err in the same cycle;
    - updates the last-served pointer;
    - returns to IDLE.
  - A response arriving in the same cycle as expiry wins: it is a normal completion with no o_err.
- When not defined: no counter is built; o_err is tied to 0 and the FSM waits indefinitely.

Test Plan:
- Single read: p0 requests addr 0x100; memory ready immediately, response 2 cycles later with 0xDEADBEEF -> o_m_req_valid at cycle 1, o_p0_rsp_valid pulse with 0xDEADBEEF, o_grant returns to 00.
- Simultaneous requests from reset: p0 addr 0x10, p1 addr 0x20 held continuously -> issue order 0x10, 0x20, 0x10, 0x20; each response routed only to its owner.
- Backpressure: i_m_req_ready low for 5 cycles during p1 write of 0x55 to 0x40 -> o_m_addr/we/wdata stable for all 6 valid cycles; exactly one handshake.
- Zero-latency memory: i_m_rsp_valid asserted with i_m_req_ready -> response pulse next cycle, new grant possible the cycle after.
- Reset asserted in WAIT_RSP, then memory response arrives after release -> all outputs 0 immediately on reset; no rsp_valid pulse after release.
- With MCI_ARB_TIMEOUT_EN and TIMEOUT=8: memory never responds to p0 -> o_p0_rsp_valid and o_err pulse together 8 cycles after ISSUE entry with rdata 0; the pending p1 request is granted next.
